dcsformer_host: RTL and testbench
=================================

# dcsformer_host

Host-side driver for the DCSformer compute core. It holds an 8x16 byte input matrix and an 8-byte weight vector loaded over a simple config port. On `start` it streams the matrix on `i_valid`/`i_data` and waits for the core's `w_ready` pulse. It then streams the weights on `w_valid`/`w_data` and captures the 8-word `o_valid`/`o_data` result burst into a readable result bank. It sits between the system-level controller or testbench sequencer and the core's input/output ports.

## Interface
- `N_ROW`, 8, matrix rows; also the weight count and the result word count.
- `N_COL`, 16, matrix columns.
- `TIMEOUT`, 1024, maximum wait in cycles for `w_ready` or for the first `o_valid`.
- Clock and reset: one clock; reset is asynchronous and active-low; ports `clk` and `rst_n`.
- `clk` in 1 clock
- `rst_n` in 1 async active-low reset
- `cfg_we` in 1 buffer write strobe
- `cfg_addr` in 8 0..127 = matrix byte (row*16+col); 128..135 = weight 0..7; 136..255 = ignored
- `cfg_data` in 8 write data
- `start` in 1 begin one transaction (sampled in IDLE only)
- `busy` out 1 high from the cycle after `start` is accepted until `done`
- `done` out 1 one-cycle pulse at transaction end
- `err` out 2 status valid with `done`: 0 = ok, 1 = `w_ready` timeout, 2 = `o_valid` timeout, 3 = short output burst
- `res_addr` in 3 result word select
- `res_data` out 32 combinational read of result word `res_addr`
- `i_valid`, `i_data` out 1/8 matrix stream to the core
- `w_valid`, `w_data` out 1/8 weight stream to the core
- `w_ready` in 1 core ready for weights (single-cycle pulse)
- `o_valid`, `o_data` in 1/32 core result stream

## Operation
- FSM states: IDLE, SEND_I, WAIT_W, SEND_W, WAIT_O, COLL.
- **IDLE**
  - `cfg_we` writes the buffer.
  - `start` → SEND_I; the byte counter is cleared.
- **SEND_I**
  - `i_valid`=1 with `i_data`=matrix[k] for k=0..127, row-major, 128 consecutive cycles with no gaps.
  - After k=127 → WAIT_W.
- **WAIT_W**
  - The watchdog counts cycles.
  - `w_ready` sampled high → SEND_W.
  - Watchdog reaches `TIMEOUT` → IDLE with `err`=1.
- **SEND_W**
  - `w_valid`=1 with `w_data`=weight[j] for j=0..7 on consecutive cycles, then → WAIT_O.
- **WAIT_O**
  - The watchdog restarts from 0.
  - `o_valid` sampled high → capture `o_data` into res[0] and go to COLL.
  - Watchdog reaches `TIMEOUT` → IDLE with `err`=2.
- **COLL**
  - Each `o_valid`=1 cycle captures into res[n] for n=1..7.
  - After res[7] is captured → IDLE, `done`=1, `err`=0.
  - `o_valid`=0 before res[7] → IDLE with `err`=3; words captured so far are kept and the rest are unchanged.
- `cfg_we` and `start` are ignored while `busy`.
- `w_ready` outside WAIT_W and `o_valid` outside WAIT_O/COLL are ignored.
- `w_ready` and `o_valid` high in the same cycle during WAIT_W: only `w_ready` is acted on.
- On entry to SEND_I the result bank is not cleared; it is overwritten word by word.
- `err` holds its value until the next `done`.

## Timing
- All DUT-facing outputs are registered.
- `start` sampled at edge t → `busy`=1 and first `i_valid` at t+1; last `i_valid` at t+128.
- `w_ready` sampled at edge t → first `w_valid` at t+1; last at t+8.
- An `o_valid` beat sampled at edge t is readable on `res_data` from t+1.
- `done` is asserted in the cycle after the final capture or error detection; `busy` falls in the same cycle.
- Minimum transaction length with zero core latency: 1+128+1+8+1+8 cycles.
- Reset values: `i_valid`, `w_valid`, `busy`, `done`=0; `i_data`, `w_data`=0; `err`=0; result bank=0; state=IDLE.
- The config buffer is not reset.
- Reset mid-transaction: streams stop immediately (asynchronous clear) and no `done` is issued.
- Watchdog: 11-bit counter. Timeout fires when the count reaches `TIMEOUT`-1 with no event, so the wait is exactly `TIMEOUT` cycles.

## Structure
- Shared package `dcs_pkg`:
  - FSM state enum.
  - `err` code constants (`ERR_OK`, `ERR_WTO`, `ERR_OTO`, `ERR_SHORT`).
  - `N_ROW`, `N_COL`, and the weight base address 128.
- Sub-module `dcs_host_buf`: 136x8 register file with a write port, a read port indexed by the stream counter, and a registered output feeding `i_data`/`w_data`.
- The FSM, counters, watchdog and result bank live in the top module.

## Test plan
- **Nominal:** matrix[k]=k, weights=1..8; responder pulses `w_ready` 5 cycles after the last `i_valid` and returns `o_data`=0x100+n, n=0..7 → `i_data` sequence 0..127; `w_data` 1..8 starting the cycle after `w_ready`; res[n]=0x100+n; `done`=1 with `err`=0.
- **W timeout:** `TIMEOUT`=16, responder never asserts `w_ready` → `done` with `err`=1 exactly 16 cycles after the last `i_valid`; `w_valid` never asserted.
- **Short burst:** `o_valid` high for 5 beats then low → `err`=3; res[0..4] updated, res[5..7] keep their old values.
- **Ignored inputs:** `start` and `cfg_we` (addr 0, data 0xFF) during SEND_I, plus an early `w_ready` pulse in SEND_I → no restart, buffer[0] unchanged, `w_valid` only after the WAIT_W `w_ready`.
- **Reset mid-stream:** `rst_n`=0 at `i_valid` beat 60 → all outputs 0 immediately; `res_data`=0 for every address; a new `start` replays from byte 0 using the retained buffer.
- **Back-to-back:** `start` asserted the cycle `done` pulses → ignored; `start` one cycle later → accepted, second transaction matches the first.

Source files
------------

// File: rtl/dcs_pkg.sv
// Shared types and constants for the DCSformer host driver.
package dcs_pkg;

    localparam int unsigned N_ROW     = 8;
    localparam int unsigned N_COL     = 16;
    localparam int unsigned N_BYTES   = N_ROW * N_COL;
    localparam int unsigned W_BASE    = 128;
    localparam int unsigned BUF_DEPTH = W_BASE + N_ROW;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned RES_W     = 32;
    localparam int unsigned RES_IDX_W = 3;
    localparam int unsigned CNT_W     = 7;
    localparam int unsigned WD_W      = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_I,
        S_WAIT_W,
        S_SEND_W,
        S_WAIT_O,
        S_COLL
    } state_e;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_WTO   = 2'd1;
    localparam logic [1:0] ERR_OTO   = 2'd2;
    localparam logic [1:0] ERR_SHORT = 2'd3;

endpackage

// File: rtl/dcsformer_host_if.sv
// Stream bundle between the host driver and the DCSformer core.
interface dcsformer_host_if;
    import dcs_pkg::*;

    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              w_ready;
    logic              o_valid;
    logic [RES_W-1:0]  o_data;

    modport master (
        output i_valid, i_data, w_valid, w_data,
        input  w_ready, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_data, w_valid, w_data,
        output w_ready, o_valid, o_data
    );

endinterface

// File: rtl/dcs_host_buf.sv
// Matrix + weight byte store; one write port, one registered read port.
module dcs_host_buf
    import dcs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] BUF_LAST = ADDR_W'(BUF_DEPTH - 1);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Storage is intentionally not reset so it survives a mid-transaction reset.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= BUF_LAST)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dcsformer_host.sv
// Host driver: streams matrix and weights to the core, collects the 8-word result.
module dcsformer_host
    import dcs_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [DATA_W-1:0]    cfg_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    input  logic [RES_IDX_W-1:0] res_addr,
    output logic [RES_W-1:0]     res_data,
    dcsformer_host_if.master     core
);

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] I_LAST   = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(N_ROW - 1);
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(N_ROW - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              i_valid_q, i_valid_d;
    logic              w_valid_q, w_valid_d;
    logic [RES_W-1:0]  res_q [N_ROW];

    logic                 rd_en_c;
    logic [ADDR_W-1:0]    rd_addr_c;
    logic                 res_we_c;
    logic [RES_IDX_W-1:0] res_idx_c;
    logic                 fin_c;
    logic [1:0]           fin_err_c;
    logic [DATA_W-1:0]    buf_rd_data;

    dcs_host_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cfg_we && (state_q == S_IDLE)),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_en   (rd_en_c),
        .rd_addr (rd_addr_c),
        .rd_data (buf_rd_data)
    );

    // Next-state: the buffer read address is the byte to present after this edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        busy_d    = busy_q;
        err_d     = err_q;
        done_d    = 1'b0;
        i_valid_d = 1'b0;
        w_valid_d = 1'b0;
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        res_we_c  = 1'b0;
        res_idx_c = '0;
        fin_c     = 1'b0;
        fin_err_c = ERR_OK;

        case (state_q)
            S_IDLE: begin
                // The done cycle itself does not accept a new start.
                if (start && !done_q) begin
                    state_d   = S_SEND_I;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    i_valid_d = 1'b1;
                    rd_en_c   = 1'b1;
                    rd_addr_c = '0;
                end
            end
            S_SEND_I: begin
                if (cnt_q == I_LAST) begin
                    state_d = S_WAIT_W;
                    wd_d    = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    i_valid_d = 1'b1;
                    rd_en_c   = 1'b1;
                    rd_addr_c = ADDR_W'(cnt_q) + ADDR_W'(1);
                end
            end
            S_WAIT_W: begin
                if (core.w_ready) begin
                    state_d   = S_SEND_W;
                    cnt_d     = '0;
                    w_valid_d = 1'b1;
                    rd_en_c   = 1'b1;
                    rd_addr_c = ADDR_W'(W_BASE);
                end else if (wd_q == WD_LAST) begin
                    fin_c     = 1'b1;
                    fin_err_c = ERR_WTO;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_SEND_W: begin
                if (cnt_q == W_LAST) begin
                    state_d = S_WAIT_O;
                    wd_d    = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    w_valid_d = 1'b1;
                    rd_en_c   = 1'b1;
                    rd_addr_c = ADDR_W'(W_BASE) + ADDR_W'(cnt_q) + ADDR_W'(1);
                end
            end
            S_WAIT_O: begin
                if (core.o_valid) begin
                    res_we_c  = 1'b1;
                    res_idx_c = '0;
                    cnt_d     = CNT_W'(1);
                    state_d   = S_COLL;
                end else if (wd_q == WD_LAST) begin
                    fin_c     = 1'b1;
                    fin_err_c = ERR_OTO;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_COLL: begin
                if (core.o_valid) begin
                    res_we_c  = 1'b1;
                    res_idx_c = cnt_q[RES_IDX_W-1:0];
                    if (cnt_q == RES_LAST) begin
                        fin_c     = 1'b1;
                        fin_err_c = ERR_OK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    fin_c     = 1'b1;
                    fin_err_c = ERR_SHORT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin_c) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = fin_err_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_OK;
            i_valid_q <= 1'b0;
            w_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            i_valid_q <= i_valid_d;
            w_valid_q <= w_valid_d;
        end
    end

    // Result bank: only written words change; unwritten words keep old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ROW; i++) begin
                res_q[i] <= '0;
            end
        end else if (res_we_c) begin
            res_q[res_idx_c] <= core.o_data;
        end
    end

    // i_data and w_data share one buffer register; each is qualified by its valid.
    assign core.i_valid = i_valid_q;
    assign core.i_data  = buf_rd_data;
    assign core.w_valid = w_valid_q;
    assign core.w_data  = buf_rd_data;

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign res_data = res_q[res_addr];

endmodule

// File: tb/tb_dcsformer_host.sv
// Directed bench for dcsformer_host: acts as sequencer and core responder.
`timescale 1ns/1ps
module tb_dcsformer_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [2:0]  res_addr;
    logic [31:0] res_data;

    dcsformer_host_if core_if ();

    dcsformer_host #(.TIMEOUT(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .res_addr (res_addr),
        .res_data (res_data),
        .core     (core_if.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0]  mat [128];
    logic [7:0]  wt [8];
    logic [31:0] exp_res [8];

    int         i_cnt, i_bad, w_cnt, w_bad, o_sent;
    int         first_i, last_i, first_w, last_w, wr_cyc, done_cyc;
    logic [7:0] first_i_data;
    logic [1:0] err_seen;
    bit         done_seen, rst_hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag);
        for (int n = 0; n < 8; n++) begin
            res_addr = 3'(n);
            #1;
            check($sformatf("%s[%0d]", tag, n), res_data, exp_res[n]);
        end
    endtask

    task automatic cfg_wr(input int addr, input logic [7:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 8'(addr);
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Called at a negedge; drives start and plays the core. Returns at the
    // negedge where done is observed (or where reset was asserted).
    task automatic run_txn(input int w_delay, input int o_delay, input int n_beats,
                           input logic [31:0] o_base, input bit noisy, input int rst_beat);
        i_cnt = 0; i_bad = 0; w_cnt = 0; w_bad = 0; o_sent = 0;
        first_i = -1; last_i = -1; first_w = -1; last_w = -1; wr_cyc = -1; done_cyc = -1;
        first_i_data = 8'hxx; err_seen = 2'b00; done_seen = 1'b0; rst_hit = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = 1'b0; cfg_we = 1'b0;
            core_if.w_ready = 1'b0; core_if.o_valid = 1'b0; core_if.o_data = '0;
            if (core_if.i_valid) begin
                if (i_cnt >= 128 || core_if.i_data !== mat[i_cnt]) i_bad++;
                if (i_cnt == 0) begin first_i = cyc; first_i_data = core_if.i_data; end
                last_i = cyc;
                i_cnt++;
            end
            if (core_if.w_valid) begin
                if (w_cnt >= 8 || core_if.w_data !== wt[w_cnt]) w_bad++;
                if (w_cnt == 0) first_w = cyc;
                last_w = cyc;
                w_cnt++;
            end
            if (done) begin
                done_seen = 1'b1; done_cyc = cyc; err_seen = err;
                break;
            end
            if (rst_beat >= 0 && core_if.i_valid && (i_cnt - 1) == rst_beat) begin
                rst_n = 1'b0; rst_hit = 1'b1;
                break;
            end
            if (noisy && i_cnt == 10) core_if.w_ready = 1'b1;
            if (noisy && i_cnt == 20) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 8'd0; cfg_data = 8'hFF;
            end
            if (w_delay >= 0 && i_cnt == 128 && wr_cyc < 0 && cyc == last_i + w_delay) begin
                core_if.w_ready = 1'b1; wr_cyc = cyc;
            end
            if (w_cnt == 8 && o_sent < n_beats && cyc >= last_w + o_delay) begin
                core_if.o_valid = 1'b1; core_if.o_data = o_base + 32'(o_sent); o_sent++;
            end
        end
        if (!rst_hit) check("txn_budget_done", 32'(done_seen), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; res_addr = '0;
        core_if.w_ready = 1'b0; core_if.o_valid = 1'b0; core_if.o_data = '0;
        for (int k = 0; k < 128; k++) mat[k] = 8'(k);
        for (int j = 0; j < 8; j++) wt[j] = 8'(j + 1);
        for (int n = 0; n < 8; n++) exp_res[n] = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_i_valid", 32'(core_if.i_valid), 32'd0);
        check("rst_w_valid", 32'(core_if.w_valid), 32'd0);
        check("rst_i_data", 32'(core_if.i_data), 32'd0);
        check_res("rst_res");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 128; k++) cfg_wr(k, mat[k]);
        for (int j = 0; j < 8; j++) cfg_wr(128 + j, wt[j]);
        cfg_wr(200, 8'h55);
        @(negedge clk);

        // Nominal: w_ready 5 cycles after last i_valid, 8 result beats.
        run_txn(5, 1, 8, 32'h100, 1'b0, -1);
        check("nom_err", 32'(err_seen), 32'd0);
        check("nom_i_cnt", 32'(i_cnt), 32'd128);
        check("nom_i_bad", 32'(i_bad), 32'd0);
        check("nom_first_i", 32'(first_i), 32'd1);
        check("nom_last_i", 32'(last_i), 32'd128);
        check("nom_first_w", 32'(first_w), 32'd134);
        check("nom_w_cnt", 32'(w_cnt), 32'd8);
        check("nom_w_bad", 32'(w_bad), 32'd0);
        check("nom_done_cyc", 32'(done_cyc), 32'd150);
        check("nom_busy_at_done", 32'(busy), 32'd0);
        for (int n = 0; n < 8; n++) exp_res[n] = 32'h100 + 32'(n);

        // Back-to-back: start during the done cycle is dropped, next one accepted.
        start = 1'b1;
        @(negedge clk);
        check("b2b_done_pulse", 32'(done), 32'd0);
        check("b2b_ignored", 32'(busy), 32'd0);
        run_txn(5, 1, 8, 32'h100, 1'b0, -1);
        check("b2b_err", 32'(err_seen), 32'd0);
        check("b2b_i_bad", 32'(i_bad), 32'd0);
        check("b2b_w_bad", 32'(w_bad), 32'd0);
        check("b2b_done_cyc", 32'(done_cyc), 32'd150);
        check_res("b2b_res");
        @(negedge clk);

        // w_ready never arrives.
        run_txn(-1, 1, 8, 32'h0, 1'b0, -1);
        check("wto_err", 32'(err_seen), 32'd1);
        check("wto_gap", 32'(done_cyc - last_i - 1), 32'd16);
        check("wto_w_cnt", 32'(w_cnt), 32'd0);
        @(negedge clk);
        check("wto_err_hold", 32'(err), 32'd1);

        // Five beats then a gap.
        run_txn(5, 1, 5, 32'h200, 1'b0, -1);
        check("short_err", 32'(err_seen), 32'd3);
        for (int n = 0; n < 5; n++) exp_res[n] = 32'h200 + 32'(n);
        check_res("short_res");
        @(negedge clk);

        // start, cfg_we and an early w_ready during SEND_I.
        run_txn(5, 1, 8, 32'h300, 1'b1, -1);
        check("noisy_err", 32'(err_seen), 32'd0);
        check("noisy_i_cnt", 32'(i_cnt), 32'd128);
        check("noisy_i_bad", 32'(i_bad), 32'd0);
        check("noisy_first_w", 32'(first_w), 32'd134);
        check("noisy_w_cnt", 32'(w_cnt), 32'd8);
        for (int n = 0; n < 8; n++) exp_res[n] = 32'h300 + 32'(n);
        check_res("noisy_res");
        @(negedge clk);

        // Reset at i_valid beat 60.
        run_txn(5, 1, 8, 32'h100, 1'b0, 60);
        check("mid_rst_hit", 32'(rst_hit), 32'd1);
        check("mid_rst_beats", 32'(i_cnt), 32'd61);
        #1;
        check("mid_rst_i_valid", 32'(core_if.i_valid), 32'd0);
        check("mid_rst_i_data", 32'(core_if.i_data), 32'd0);
        check("mid_rst_w_valid", 32'(core_if.w_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        for (int n = 0; n < 8; n++) exp_res[n] = '0;
        check_res("mid_rst_res");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Replay from retained buffer; byte 0 must still be 0.
        run_txn(5, 1, 8, 32'h100, 1'b0, -1);
        check("replay_err", 32'(err_seen), 32'd0);
        check("replay_buf0_kept", 32'(first_i_data), 32'd0);
        check("replay_i_cnt", 32'(i_cnt), 32'd128);
        check("replay_i_bad", 32'(i_bad), 32'd0);
        check("replay_w_bad", 32'(w_bad), 32'd0);
        for (int n = 0; n < 8; n++) exp_res[n] = 32'h100 + 32'(n);
        check_res("replay_res");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
